// File: rtl/dht22_pkg.sv
// dht22_pkg: DHT22 frame layout, default limits and conditioner FSM states
package dht22_pkg;
  localparam int HUM_MSB = 39;
  localparam int HUM_LSB = 24;
  localparam int TEMP_SIGN_BIT = 23;
  localparam int TEMP_MAG_MSB = 22;
  localparam int TEMP_MAG_LSB = 8;
  localparam int CSUM_MSB = 7;
  localparam int CSUM_LSB = 0;
  localparam logic [15:0] DEF_HUM_MAX = 16'd1000;
  localparam logic [14:0] DEF_TEMP_MAG_MAX = 15'd800;
  typedef enum logic [1:0] {IDLE, CHECK, ACCUM, EMIT} state_t;
  function automatic logic [7:0] csum(input logic [39:0] f);
    return f[39:32] + f[31:24] + f[23:16] + f[15:8];
  endfunction
endpackage

// File: rtl/dht22_avg_window.sv
// dht22_avg_window: circular sample buffer with running sums and fill count
module dht22_avg_window import dht22_pkg::*; #(
  parameter int AVG_LOG2 = 2,
  localparam int TW = 17 + AVG_LOG2,
  localparam int HW = 16 + AVG_LOG2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic signed [15:0]   t_in,
  input  logic [15:0]          h_in,
  output logic                 full,
  output logic signed [TW-1:0] sum_t_nxt,
  output logic [HW-1:0]        sum_h_nxt
);
  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int PW = AVG_LOG2 > 0 ? AVG_LOG2 : 1;
  logic signed [15:0] buf_t [DEPTH];
  logic [15:0] buf_h [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [AVG_LOG2:0] fill;
  logic signed [TW-1:0] sum_t;
  logic [HW-1:0] sum_h;
  logic was_full;
  assign was_full = fill == (AVG_LOG2+1)'(DEPTH);
  // full reflects the window after the current push, so the caller can emit in the same cycle
  assign full = was_full | (fill == (AVG_LOG2+1)'(DEPTH-1));
  assign sum_t_nxt = sum_t + TW'(t_in) - TW'(was_full ? buf_t[wr_ptr] : 16'sd0);
  assign sum_h_nxt = sum_h + HW'(h_in) - HW'(was_full ? buf_h[wr_ptr] : 16'd0);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      fill <= '0;
      sum_t <= '0;
      sum_h <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_t[i] <= '0;
        buf_h[i] <= '0;
      end
    end else if (push) begin
      buf_t[wr_ptr] <= t_in;
      buf_h[wr_ptr] <= h_in;
      wr_ptr <= wr_ptr == PW'(DEPTH-1) ? '0 : wr_ptr + 1'b1;
      fill <= was_full ? fill : fill + 1'b1;
      sum_t <= sum_t_nxt;
      sum_h <= sum_h_nxt;
    end
  end
endmodule

// File: rtl/dht22_sample_conditioner.sv
// dht22_sample_conditioner: validate DHT22 frames, average them and flag over-temperature
module dht22_sample_conditioner import dht22_pkg::*; #(
  parameter int AVG_LOG2 = 2,
  parameter logic signed [15:0] TEMP_HI = 16'sd500,
  parameter logic signed [15:0] TEMP_HYST = 16'sd20,
  parameter logic [15:0] HUM_MAX = DEF_HUM_MAX,
  parameter logic [14:0] TEMP_MAG_MAX = DEF_TEMP_MAG_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [39:0] frame_in,
  input  logic        frame_valid,
  output logic [15:0] temp_out,
  output logic [15:0] hum_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        temp_alarm,
  output logic        frame_err,
  output logic [7:0]  err_cnt,
  output logic [7:0]  drop_cnt
);
  localparam int TW = 17 + AVG_LOG2;
  localparam int HW = 16 + AVG_LOG2;
  state_t state;
  logic [39:0] frame;
  logic [15:0] hum;
  logic [14:0] mag;
  logic signed [15:0] temp, avg_t;
  logic [15:0] avg_h;
  logic bad, full;
  logic signed [TW-1:0] sum_t_nxt;
  logic [HW-1:0] sum_h_nxt;
  assign hum = frame[HUM_MSB:HUM_LSB];
  assign mag = frame[TEMP_MAG_MSB:TEMP_MAG_LSB];
  assign temp = frame[TEMP_SIGN_BIT] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  assign bad = csum(frame) != frame[CSUM_MSB:CSUM_LSB] || hum > HUM_MAX || mag > TEMP_MAG_MAX;
  assign avg_t = 16'(sum_t_nxt >>> AVG_LOG2);
  assign avg_h = 16'(sum_h_nxt >> AVG_LOG2);
  dht22_avg_window #(.AVG_LOG2(AVG_LOG2)) u_win (
    .clk(clk), .reset(reset), .push(state == ACCUM), .t_in(temp), .h_in(hum),
    .full(full), .sum_t_nxt(sum_t_nxt), .sum_h_nxt(sum_h_nxt)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      frame <= '0;
      temp_out <= '0;
      hum_out <= '0;
      out_valid <= 1'b0;
      temp_alarm <= 1'b0;
      frame_err <= 1'b0;
      err_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      frame_err <= 1'b0;
      drop_cnt <= frame_valid && state != IDLE && drop_cnt != 8'hFF ? drop_cnt + 1'b1 : drop_cnt;
      case (state)
        IDLE: if (frame_valid) begin
          frame <= frame_in;
          state <= CHECK;
        end
        CHECK: begin
          frame_err <= bad;
          err_cnt <= bad && err_cnt != 8'hFF ? err_cnt + 1'b1 : err_cnt;
          state <= bad ? IDLE : ACCUM;
        end
        ACCUM: begin
          state <= full ? EMIT : IDLE;
          if (full) begin
            temp_out <= avg_t;
            hum_out <= avg_h;
            out_valid <= 1'b1;
            temp_alarm <= avg_t >= TEMP_HI ? 1'b1 : avg_t < TEMP_HI - TEMP_HYST ? 1'b0 : temp_alarm;
          end
        end
        EMIT: if (out_ready) begin
          out_valid <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dht22_sample_conditioner.sv
// tb_dht22_sample_conditioner: scoreboard bench for pass-through and 4-sample averaging instances
module tb_dht22_sample_conditioner;
  logic clk = 1'b0, reset = 1'b1, fv = 1'b0, out_ready = 1'b0, sel = 1'b0;
  logic [39:0] frame_in = '0;
  logic [15:0] t0, h0, t2, h2, t, h;
  logic ov0, a0, fe0, ov2, a2, fe2, ov, a, fe;
  logic [7:0] ec0, dc0, ec2, dc2, ec, dc;
  typedef struct {logic [15:0] t; logic [15:0] h; logic a;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int wt[$], wh[$];
  logic malm = 1'b0;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  dht22_sample_conditioner #(.AVG_LOG2(0)) dut0 (
    .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(fv & ~sel),
    .temp_out(t0), .hum_out(h0), .out_valid(ov0), .out_ready(out_ready & ~sel),
    .temp_alarm(a0), .frame_err(fe0), .err_cnt(ec0), .drop_cnt(dc0));
  dht22_sample_conditioner #(.AVG_LOG2(2)) dut2 (
    .clk(clk), .reset(reset), .frame_in(frame_in), .frame_valid(fv & sel),
    .temp_out(t2), .hum_out(h2), .out_valid(ov2), .out_ready(out_ready & sel),
    .temp_alarm(a2), .frame_err(fe2), .err_cnt(ec2), .drop_cnt(dc2));

  assign t = sel ? t2 : t0;
  assign h = sel ? h2 : h0;
  assign ov = sel ? ov2 : ov0;
  assign a = sel ? a2 : a0;
  assign fe = sel ? fe2 : fe0;
  assign ec = sel ? ec2 : ec0;
  assign dc = sel ? dc2 : dc0;

  function automatic logic [39:0] mk(input logic [15:0] hv, input int tv);
    logic [15:0] tsm;
    logic [7:0] c;
    tsm = tv < 0 ? {1'b1, 15'(-tv)} : {1'b0, 15'(tv)};
    c = hv[15:8] + hv[7:0] + tsm[15:8] + tsm[7:0];
    return {hv, tsm, c};
  endfunction

  task automatic model(input logic [39:0] f);
    int s, st, sh, n, q;
    n = sel ? 4 : 1;
    s = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
    if (s != int'(f[7:0]) || int'(f[39:24]) > 1000 || int'(f[22:8]) > 800) return;
    wt.push_back(f[23] ? -int'(f[22:8]) : int'(f[22:8]));
    wh.push_back(int'(f[39:24]));
    if (wt.size() > n) begin
      void'(wt.pop_front());
      void'(wh.pop_front());
    end
    if (wt.size() < n) return;
    st = 0;
    sh = 0;
    foreach (wt[i]) begin
      st += wt[i];
      sh += wh[i];
    end
    q = st / n;
    if (st % n != 0 && st < 0) q--;
    malm = q >= 500 ? 1'b1 : q < 480 ? 1'b0 : malm;
    sb.push_back('{16'(q), 16'(sh / n), malm});
  endtask

  task automatic send(input logic [39:0] f);
    frame_in = f;
    fv = 1'b1;
    @(posedge clk); #1;
    fv = 1'b0;
    model(f);
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_ov(output int c);
    c = 0;
    while (!ov && c < 20) begin @(posedge clk); #1; c++; end
    if (!ov) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_ov: out_valid=0 after %0d cycles, required 1", c);
    end
  endtask

  task automatic accept();
    int c;
    wait_ov(c);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; fv = 1'b0; out_ready = 1'b0;
    sb.delete(); wt.delete(); wh.delete(); malm = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(1);
  endtask

  always @(negedge clk) begin
    if (!reset && ov && out_ready) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard: unexpected sample temp=%0d hum=%0d, required none", $signed(t), h);
      end else begin
        mon_e = sb.pop_front();
        if (t !== mon_e.t || h !== mon_e.h || a !== mon_e.a) begin
          n_bad++;
          $display("FAIL scoreboard: got t=%0d h=%0d a=%0b, required t=%0d h=%0d a=%0b",
                   $signed(t), h, a, $signed(mon_e.t), mon_e.h, mon_e.a);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    n_cmp++;
    if ({ov0, a0, fe0, ec0, dc0, t0, h0} !== '0) begin
      n_bad++; $display("FAIL reset0: outputs=%h, required 0", {ov0, a0, fe0, ec0, dc0, t0, h0});
    end
    n_cmp++;
    if ({ov2, a2, fe2, ec2, dc2, t2, h2} !== '0) begin
      n_bad++; $display("FAIL reset2: outputs=%h, required 0", {ov2, a2, fe2, ec2, dc2, t2, h2});
    end
    reset = 1'b0;
    tick(1);
  endtask

  task automatic test_pass();
    int c;
    sel = 1'b0;
    do_reset();
    send(40'h028C015FEE);
    wait_ov(c);
    n_cmp++;
    if (c !== 2) begin n_bad++; $display("FAIL latency: %0d edges after strobe edge, required 2", c); end
    n_cmp++;
    if (t !== 16'd351 || h !== 16'd652 || a !== 1'b0) begin
      n_bad++; $display("FAIL pass: t=%0d h=%0d a=%0b, required 351 652 0", $signed(t), h, a);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      n_cmp++;
      if (ov !== 1'b1 || t !== 16'd351 || h !== 16'd652) begin
        n_bad++; $display("FAIL hold%0d: ov=%0b t=%0d h=%0d, required 1 351 652", i, ov, $signed(t), h);
      end
    end
    accept();
    n_cmp++;
    if (ov !== 1'b0) begin n_bad++; $display("FAIL release: ov=%0b, required 0", ov); end
  endtask

  task automatic test_negative();
    int c;
    send(40'h028C806573);
    wait_ov(c);
    n_cmp++;
    if (t !== 16'hFF9B) begin n_bad++; $display("FAIL neg: t=%h, required ff9b", t); end
    accept();
    send(40'h028C80000E);
    wait_ov(c);
    n_cmp++;
    if (t !== 16'h0000) begin n_bad++; $display("FAIL negzero: t=%h, required 0000", t); end
    accept();
  endtask

  task automatic test_bad();
    send(40'h028C015FEF);
    tick(1);
    n_cmp++;
    if (fe !== 1'b1) begin n_bad++; $display("FAIL err_pulse: frame_err=%0b, required 1", fe); end
    tick(1);
    n_cmp++;
    if (fe !== 1'b0 || ov !== 1'b0 || ec !== 8'd1) begin
      n_bad++; $display("FAIL err_after: fe=%0b ov=%0b err_cnt=%0d, required 0 0 1", fe, ov, ec);
    end
    send(mk(16'd1001, 200));
    tick(2);
    n_cmp++;
    if (ec !== 8'd2) begin n_bad++; $display("FAIL hum_range: err_cnt=%0d, required 2", ec); end
    send(mk(16'd500, 801));
    tick(2);
    n_cmp++;
    if (ec !== 8'd3) begin n_bad++; $display("FAIL temp_range: err_cnt=%0d, required 3", ec); end
    for (int i = 0; i < 297; i++) begin
      send(40'h028C015FEF);
      tick(1);
    end
    n_cmp++;
    if (ec !== 8'd255 || ov !== 1'b0 || dc !== 8'd0) begin
      n_bad++; $display("FAIL err_sat: err_cnt=%0d ov=%0b drop=%0d, required 255 0 0", ec, ov, dc);
    end
  endtask

  task automatic test_avg();
    int c;
    int temps[9] = '{100, 200, 300, 401, 100, -1, -2, -2, -2};
    int hums[9] = '{400, 500, 600, 700, 600, 500, 500, 500, 500};
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      send(mk(16'(hums[i]), temps[i]));
      if (i < 3) begin
        tick(3);
        n_cmp++;
        if (ov !== 1'b0) begin n_bad++; $display("FAIL fill%0d: ov=%0b, required 0", i, ov); end
      end else begin
        wait_ov(c);
        if (i == 3 || i == 4) begin
          n_cmp++;
          if (t !== 16'd250 || h !== (i == 3 ? 16'd550 : 16'd600)) begin
            n_bad++; $display("FAIL avg%0d: t=%0d h=%0d, required 250 %0d", i, $signed(t), h, i == 3 ? 550 : 600);
          end
        end
        if (i == 8) begin
          n_cmp++;
          if (t !== 16'hFFFE) begin n_bad++; $display("FAIL avg_neg: t=%0d, required -2", $signed(t)); end
        end
        accept();
      end
    end
  endtask

  task automatic test_alarm();
    int temps[4] = '{499, 500, 481, 479};
    logic exp_a[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    int c;
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(mk(16'd500, temps[i]));
      wait_ov(c);
      n_cmp++;
      if (a !== exp_a[i]) begin n_bad++; $display("FAIL alarm%0d: a=%0b, required %0b", i, a, exp_a[i]); end
      accept();
    end
  endtask

  task automatic test_drop_reset();
    send(40'h028C015FEF);
    tick(1);
    send(mk(16'd500, 600));
    frame_in = mk(16'd100, 100);
    fv = 1'b1;
    tick(1);
    fv = 1'b0;
    tick(1);
    n_cmp++;
    if (ov !== 1'b1) begin n_bad++; $display("FAIL drop_emit: ov=%0b, required 1", ov); end
    fv = 1'b1;
    tick(1);
    fv = 1'b0;
    n_cmp++;
    if (dc !== 8'd2 || t !== 16'd600 || h !== 16'd500 || a !== 1'b1 || ov !== 1'b1 || ec !== 8'd1) begin
      n_bad++; $display("FAIL drop: drop=%0d t=%0d h=%0d a=%0b ov=%0b err=%0d, required 2 600 500 1 1 1",
                        dc, $signed(t), h, a, ov, ec);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({ov, a, ec, dc, t, h} !== '0) begin
      n_bad++; $display("FAIL async_reset: ov=%0b a=%0b err=%0d drop=%0d t=%0d, required all 0", ov, a, ec, dc, $signed(t));
    end
    do_reset();
  endtask

  task automatic test_refill();
    int c;
    sel = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      send(mk(16'd300, 10 * i));
      if (i < 4) begin
        tick(3);
        n_cmp++;
        if (ov !== 1'b0) begin n_bad++; $display("FAIL refill%0d: ov=%0b, required 0", i, ov); end
      end
    end
    wait_ov(c);
    n_cmp++;
    if (t !== 16'd25 || h !== 16'd300) begin
      n_bad++; $display("FAIL refill_avg: t=%0d h=%0d, required 25 300", $signed(t), h);
    end
    accept();
  endtask

  initial begin
    test_reset();
    test_pass();
    test_negative();
    test_bad();
    test_avg();
    test_alarm();
    test_drop_reset();
    test_refill();
    tick(2);
    n_cmp++;
    if (sb.size() !== 0) begin n_bad++; $display("FAIL sb_drain: %0d samples pending, required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
